iter_loop_ctrl: RTL and testbench

- Moore FSM that sequences an iteration loop built around the team's 3-bit up counter (clear/increment inputs, 3-bit value output).
- Clears the counter, issues one datapath step per iteration, waits for step completion, increments the counter, and stops after a programmable terminal count.
- Sits between the top-level start/done handshake and the loop datapath (counter plus step unit).

---
 rtl/iter_loop_ctrl_pkg.sv | 24 ++
 rtl/iter_loop_ctrl.sv | 118 +++++++++++
 tb/tb_iter_loop_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/iter_loop_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : iter_loop_ctrl_pkg
// Brief   : Shared types and constants for the iteration loop controller.
// Revision: 1.0 - initial release
// ============================================================================
package iter_loop_ctrl_pkg;

  // Width of the iteration counter value and of the terminal-count bound.
  localparam int C_CNT_W = 3;

  // Controller states. The 3-bit encoding is fixed so that the state register
  // width does not depend on tool enum sizing.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    STEP = 3'd2,
    WAIT = 3'd3,
    NEXT = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage : iter_loop_ctrl_pkg
`default_nettype wire

// File: rtl/iter_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : iter_loop_ctrl
// Brief   : Moore FSM sequencing an iteration loop around an external up
//           counter: clear, step, wait for completion, increment, and stop
//           once the counter reaches the bound latched at start.
// Revision: 1.0 - initial release
// ============================================================================
module iter_loop_ctrl
  import iter_loop_ctrl_pkg::*;
#(
  parameter int CNT_W = C_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] last_cnt,
  input  logic             abort,
  input  logic [CNT_W-1:0] cnt_val,
  input  logic             step_done,
  output logic             cnt_clr,
  output logic             cnt_inc,
  output logic             ld_init,
  output logic             step_go,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_bound;

  // State register plus the bound captured when a start is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_bound <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && start) begin
        r_bound <= last_cnt;
      end
    end
  end

  // Next-state logic; abort outranks the normal flow in every active state
  // but is ignored in DONE so a finished loop still reports completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = INIT;
        end
      end
      INIT: begin
        w_state_nxt = abort ? IDLE : STEP;
      end
      STEP: begin
        w_state_nxt = abort ? IDLE : WAIT;
      end
      WAIT: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (step_done) begin
          // The counter is compared before the increment, so the last step
          // is the one that ran with cnt_val equal to the bound.
          w_state_nxt = (cnt_val == r_bound) ? DONE : NEXT;
        end
      end
      NEXT: begin
        w_state_nxt = abort ? IDLE : STEP;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Moore output decode: every output is a function of r_state only.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    ld_init = 1'b0;
    step_go = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (r_state)
      INIT: begin
        cnt_clr = 1'b1;
        ld_init = 1'b1;
        busy    = 1'b1;
      end
      STEP: begin
        step_go = 1'b1;
        busy    = 1'b1;
      end
      WAIT: begin
        busy    = 1'b1;
      end
      NEXT: begin
        cnt_inc = 1'b1;
        busy    = 1'b1;
      end
      DONE: begin
        done    = 1'b1;
      end
      default: begin
        busy    = 1'b0;
      end
    endcase
  end

endmodule : iter_loop_ctrl
`default_nettype wire

// File: tb/tb_iter_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_iter_loop_ctrl
// Brief   : Directed self-checking bench for iter_loop_ctrl with a 3-bit up
//           counter model attached to cnt_clr/cnt_inc/cnt_val.
// Revision: 1.0 - initial release
// ============================================================================
module tb_iter_loop_ctrl;
  import iter_loop_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] last_cnt = 3'd0;
  logic       abort = 1'b0;
  logic [2:0] cnt_val;
  logic       step_done = 1'b0;
  logic       cnt_clr, cnt_inc, ld_init, step_go, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  // Per-run statistics gathered at the falling edge.
  int cyc = 0;
  int n_go, n_inc, n_clr, n_ld, n_done, n_busy;
  int done_cyc, busy_first, busy_last;
  bit wrap_seen;
  bit finished;

  iter_loop_ctrl #(.CNT_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .last_cnt (last_cnt),
    .abort    (abort),
    .cnt_val  (cnt_val),
    .step_done(step_done),
    .cnt_clr  (cnt_clr),
    .cnt_inc  (cnt_inc),
    .ld_init  (ld_init),
    .step_go  (step_go),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // External 3-bit up counter model.
  logic [2:0] r_cnt = 3'd0;
  assign cnt_val = r_cnt;
  always @(posedge clk) begin
    if (reset)        r_cnt <= 3'd0;
    else if (cnt_clr) r_cnt <= 3'd0;
    else if (cnt_inc) r_cnt <= r_cnt + 3'd1;
  end

  // Output monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (step_go) n_go++;
    if (cnt_inc) n_inc++;
    if (cnt_clr) n_clr++;
    if (ld_init) n_ld++;
    if (cnt_inc && (r_cnt == 3'd7)) wrap_seen = 1'b1;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy) begin
      n_busy++;
      if (busy_first < 0) busy_first = cyc;
      busy_last = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [5:0] outs();
    return {cnt_clr, cnt_inc, ld_init, step_go, busy, done};
  endfunction

  // Run one loop. w = WAIT length in cycles before step_done; spur adds
  // step_done pulses in STEP/NEXT; abort_wait>0 cancels in that WAIT (with
  // reset instead of abort if use_rst); noise adds stray starts.
  task automatic run_loop(input int b, input int w, input bit spur,
                          input int abort_wait, input bit use_rst, input bit noise);
    int  wc;
    int  waits_seen;
    bit  in_wait;
    start = 1'b1;
    last_cnt = 3'(b);
    n_go = 0; n_inc = 0; n_clr = 0; n_ld = 0; n_done = 0; n_busy = 0;
    done_cyc = -1; busy_first = -1; busy_last = -1; wrap_seen = 1'b0;
    cyc = 0; wc = 0; waits_seen = 0; finished = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k < 300 && !finished; k++) begin
      in_wait = busy && !step_go && !cnt_inc && !cnt_clr;
      if (in_wait) begin
        if (wc == 0) waits_seen++;
        wc++;
      end else begin
        wc = 0;
      end
      step_done = (in_wait && (wc == w)) || (spur && (step_go || cnt_inc));
      abort = 1'b0;
      reset = 1'b0;
      if ((abort_wait != 0) && in_wait && (waits_seen == abort_wait)) begin
        if (use_rst) reset = 1'b1;
        else         abort = 1'b1;
        finished = 1'b1;
      end
      if (noise) begin
        start    = (cyc == 3) || (cyc == 10) || done;
        last_cnt = 3'd6;
      end
      if (done) finished = 1'b1;
      tick();
    end
    step_done = 1'b0;
    abort     = 1'b0;
    reset     = 1'b0;
    start     = 1'b0;
    chk("run_completes", 32'(finished), 32'd1);
  endtask

  initial begin
    // Reset then idle
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    chk("rst_bound", 32'(dut.r_bound), 32'd0);
    chk("rst_outs",  32'(outs()), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outs", 32'(outs()), 32'd0);
    end

    // Normal run, bound 2
    run_loop(2, 1, 1'b0, 0, 1'b0, 1'b0);
    chk("b2_step_go", 32'(n_go), 32'd3);
    chk("b2_cnt_inc", 32'(n_inc), 32'd2);
    chk("b2_cnt_clr", 32'(n_clr), 32'd1);
    chk("b2_ld_init", 32'(n_ld), 32'd1);
    chk("b2_done_n",  32'(n_done), 32'd1);
    chk("b2_done_cyc", 32'(done_cyc), 32'd10);
    chk("b2_busy_first", 32'(busy_first), 32'd1);
    chk("b2_busy_last", 32'(busy_last), 32'd9);
    chk("b2_busy_n", 32'(n_busy), 32'd9);
    chk("b2_cnt_final", 32'(cnt_val), 32'd2);
    chk("b2_idle_after", 32'(dut.r_state), 32'(IDLE));

    // Bound 0
    run_loop(0, 1, 1'b0, 0, 1'b0, 1'b0);
    chk("b0_step_go", 32'(n_go), 32'd1);
    chk("b0_cnt_inc", 32'(n_inc), 32'd0);
    chk("b0_done_cyc", 32'(done_cyc), 32'd4);
    chk("b0_busy_n", 32'(n_busy), 32'd3);

    // Bound 7
    run_loop(7, 1, 1'b0, 0, 1'b0, 1'b0);
    chk("b7_step_go", 32'(n_go), 32'd8);
    chk("b7_cnt_inc", 32'(n_inc), 32'd7);
    chk("b7_no_wrap", 32'(wrap_seen), 32'd0);
    chk("b7_done_cyc", 32'(done_cyc), 32'd25);
    chk("b7_busy_last", 32'(busy_last), 32'd24);
    chk("b7_cnt_final", 32'(cnt_val), 32'd7);

    // Slow datapath with spurious step_done in STEP/NEXT
    run_loop(1, 5, 1'b1, 0, 1'b0, 1'b0);
    chk("slow_step_go", 32'(n_go), 32'd2);
    chk("slow_cnt_inc", 32'(n_inc), 32'd1);
    chk("slow_done_cyc", 32'(done_cyc), 32'd15);
    chk("slow_busy_n", 32'(n_busy), 32'd14);

    // Abort in second WAIT
    run_loop(5, 1, 1'b0, 2, 1'b0, 1'b0);
    chk("abort_state", 32'(dut.r_state), 32'(IDLE));
    chk("abort_outs", 32'(outs()), 32'd0);
    chk("abort_bound", 32'(dut.r_bound), 32'd5);
    tick();
    tick();
    tick();
    chk("abort_no_done", 32'(n_done), 32'd0);
    chk("abort_step_go", 32'(n_go), 32'd2);

    // Reset in second WAIT
    run_loop(5, 1, 1'b0, 2, 1'b1, 1'b0);
    chk("rstmid_state", 32'(dut.r_state), 32'(IDLE));
    chk("rstmid_bound", 32'(dut.r_bound), 32'd0);
    chk("rstmid_outs", 32'(outs()), 32'd0);
    tick();
    tick();
    tick();
    chk("rstmid_no_done", 32'(n_done), 32'd0);

    // Stray starts and last_cnt change during a bound-2 run
    run_loop(2, 1, 1'b0, 0, 1'b0, 1'b1);
    chk("noise_step_go", 32'(n_go), 32'd3);
    chk("noise_cnt_inc", 32'(n_inc), 32'd2);
    chk("noise_done_cyc", 32'(done_cyc), 32'd10);
    chk("noise_bound", 32'(dut.r_bound), 32'd2);
    chk("noise_state", 32'(dut.r_state), 32'(IDLE));
    tick();
    tick();
    tick();
    chk("noise_no_rerun", 32'(n_busy), 32'd9);
    chk("noise_done_n", 32'(n_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_iter_loop_ctrl
`default_nettype wire
